// File: rtl/quadrilatero_rf_scoreboard_pkg.sv
// rtl/quadrilatero_rf_scoreboard_pkg.sv - shared types and helpers for the matrix RF hazard scoreboard
package quadrilatero_rf_scoreboard_pkg;

   localparam int X_ID_WIDTH = 4;
   // Operand/index lists are zero-padded to these bounds before matching.
   localparam int SB_MAX_OPS = 16;
   localparam int SB_IDX_W   = 8;

   typedef struct packed {
      logic [SB_IDX_W-1:0] rd_cnt;
      logic                wr_pend;
      logic [31:0]         wr_id;
   } sb_entry_t;

   function automatic logic [SB_IDX_W-1:0] popcount_match(
      input logic [SB_IDX_W-1:0]            r,
      input logic [SB_MAX_OPS*SB_IDX_W-1:0] regs,
      input logic [SB_MAX_OPS-1:0]          en
   );
      logic [SB_IDX_W-1:0] n;
      n = '0;
      for (int i = 0; i < SB_MAX_OPS; i++) begin
         if (en[i] && (regs[i*SB_IDX_W +: SB_IDX_W] == r)) begin
            n = n + 1'b1;
         end
      end
      return n;
   endfunction

endpackage

// File: rtl/quadrilatero_sb_entry.sv
// rtl/quadrilatero_sb_entry.sv - one register's reader count, pending writer, writer ID and sticky error
module quadrilatero_sb_entry #(
   parameter int CW       = 2,
   parameter int ID_WIDTH = 4
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic [CW+1:0]       inc_i,
   input  logic [CW+1:0]       dec_i,
   input  logic                set_wr_i,
   input  logic [ID_WIDTH-1:0] set_id_i,
   input  logic [1:0]          wr_rel_cnt_i,
   output logic [CW-1:0]       rd_cnt_o,
   output logic                wr_pend_o,
   output logic [ID_WIDTH-1:0] wr_id_o,
   output logic                err_o
);

   logic [CW-1:0]       rd_cnt_q, rd_cnt_d;
   logic                wr_pend_q, wr_pend_d;
   logic [ID_WIDTH-1:0] wr_id_q, wr_id_d;
   logic                err_q, err_d;
   logic [CW+1:0]       sum;
   logic                underflow;
   logic                wr_rel;
   logic                wr_err;

   always_comb begin
      // Two extra bits: sign for underflow, one for headroom above the count range.
      sum       = {2'b00, rd_cnt_q} + inc_i - dec_i;
      underflow = sum[CW+1];
      rd_cnt_d  = rd_cnt_q;
      if (underflow) begin
         rd_cnt_d = '0;
      end else if (sum[CW]) begin
         rd_cnt_d = '1;
      end else begin
         rd_cnt_d = sum[CW-1:0];
      end

      wr_rel    = |wr_rel_cnt_i;
      wr_err    = wr_rel_cnt_i[1] || (wr_rel && !wr_pend_q);
      wr_pend_d = wr_pend_q;
      wr_id_d   = wr_id_q;
      if (wr_rel) begin
         wr_pend_d = 1'b0;
         wr_id_d   = '0;
      end
      if (set_wr_i) begin
         wr_pend_d = 1'b1;
         wr_id_d   = set_id_i;
      end
      err_d = err_q | underflow | wr_err;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         rd_cnt_q  <= '0;
         wr_pend_q <= 1'b0;
         wr_id_q   <= '0;
         err_q     <= 1'b0;
      end else begin
         rd_cnt_q  <= rd_cnt_d;
         wr_pend_q <= wr_pend_d;
         wr_id_q   <= wr_id_d;
         err_q     <= err_d;
      end
   end

   assign rd_cnt_o  = rd_cnt_q;
   assign wr_pend_o = wr_pend_q;
   assign wr_id_o   = wr_id_q;
   assign err_o     = err_q;

endmodule

// File: rtl/quadrilatero_rf_scoreboard.sv
// rtl/quadrilatero_rf_scoreboard.sv - RAW/WAW/WAR and reader-saturation hazard scoreboard for the matrix RF
module quadrilatero_rf_scoreboard
   import quadrilatero_rf_scoreboard_pkg::*;
#(
   parameter int N_REGS      = 8,
   parameter int MAX_RD_OPS  = 3,
   parameter int READ_PORTS  = 4,
   parameter int WRITE_PORTS = 3,
   parameter int MAX_READERS = 3,
   parameter int ID_WIDTH    = X_ID_WIDTH,
   localparam int RW         = $clog2(N_REGS),
   localparam int CW         = $clog2(MAX_READERS + 1)
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         flush_i,
   input  logic                         issue_valid_i,
   output logic                         issue_ready_o,
   input  logic [ID_WIDTH-1:0]          issue_id_i,
   input  logic [MAX_RD_OPS-1:0]        issue_rd_en_i,
   input  logic [MAX_RD_OPS*RW-1:0]     issue_rd_reg_i,
   input  logic                         issue_wr_en_i,
   input  logic [RW-1:0]                issue_wr_reg_i,
   input  logic [READ_PORTS-1:0]        rd_rel_valid_i,
   input  logic [READ_PORTS*RW-1:0]     rd_rel_reg_i,
   input  logic [WRITE_PORTS-1:0]       wr_rel_valid_i,
   input  logic [WRITE_PORTS*RW-1:0]    wr_rel_reg_i,
   output logic [N_REGS-1:0]            rd_busy_o,
   output logic [N_REGS-1:0]            wr_busy_o,
   output logic [N_REGS*ID_WIDTH-1:0]   wr_id_o,
   output logic                         err_o,
   output logic                         idle_o
);

   logic [SB_MAX_OPS*SB_IDX_W-1:0] iss_pad, rdr_pad, wrr_pad;
   logic [SB_MAX_OPS-1:0]          iss_en, rdr_en, wrr_en;
   logic [SB_IDX_W-1:0]            occ      [N_REGS];
   logic [SB_IDX_W-1:0]            wr_hits  [N_REGS];
   logic [CW+1:0]                  dec_cnt  [N_REGS];
   logic [1:0]                     wr_rel_cnt [N_REGS];
   logic [CW-1:0]                  rd_cnt   [N_REGS];
   logic [N_REGS-1:0]              wr_pend;
   logic [N_REGS-1:0]              err_vec;
   logic                           hazard;
   logic                           accept;

   // Widen every index list to the package's fixed match format.
   always_comb begin
      iss_pad = '0;
      rdr_pad = '0;
      wrr_pad = '0;
      iss_en  = '0;
      rdr_en  = '0;
      wrr_en  = '0;
      for (int i = 0; i < MAX_RD_OPS; i++) begin
         iss_pad[i*SB_IDX_W +: SB_IDX_W] = SB_IDX_W'(issue_rd_reg_i[i*RW +: RW]);
         iss_en[i]                       = issue_rd_en_i[i];
      end
      for (int i = 0; i < READ_PORTS; i++) begin
         rdr_pad[i*SB_IDX_W +: SB_IDX_W] = SB_IDX_W'(rd_rel_reg_i[i*RW +: RW]);
         rdr_en[i]                       = rd_rel_valid_i[i];
      end
      for (int i = 0; i < WRITE_PORTS; i++) begin
         wrr_pad[i*SB_IDX_W +: SB_IDX_W] = SB_IDX_W'(wr_rel_reg_i[i*RW +: RW]);
         wrr_en[i]                       = wr_rel_valid_i[i];
      end
   end

   // Hazards look at registered state only; same-cycle releases are not bypassed.
   always_comb begin
      hazard = 1'b0;
      for (int r = 0; r < N_REGS; r++) begin
         occ[r]        = popcount_match(SB_IDX_W'(r), iss_pad, iss_en);
         dec_cnt[r]    = (CW+2)'(popcount_match(SB_IDX_W'(r), rdr_pad, rdr_en));
         wr_hits[r]    = popcount_match(SB_IDX_W'(r), wrr_pad, wrr_en);
         wr_rel_cnt[r] = (wr_hits[r] > SB_IDX_W'(1)) ? 2'd2 : wr_hits[r][1:0];
         if ((occ[r] != '0) && wr_pend[r]) begin
            hazard = 1'b1;
         end
         if ((9'(rd_cnt[r]) + 9'(occ[r])) > 9'(MAX_READERS)) begin
            hazard = 1'b1;
         end
         if (issue_wr_en_i && (issue_wr_reg_i == RW'(r)) &&
             (wr_pend[r] || (rd_cnt[r] != '0))) begin
            hazard = 1'b1;
         end
      end
   end

   assign issue_ready_o = rst_ni && !flush_i && !hazard;
   assign accept        = issue_valid_i && issue_ready_o;

   for (genvar r = 0; r < N_REGS; r++) begin : g_entry
      quadrilatero_sb_entry #(
         .CW       (CW),
         .ID_WIDTH (ID_WIDTH)
      ) u_entry (
         .clk_i        (clk_i),
         .rst_ni       (rst_ni),
         .flush_i      (flush_i),
         .inc_i        (accept ? (CW+2)'(occ[r]) : '0),
         .dec_i        (dec_cnt[r]),
         .set_wr_i     (accept && issue_wr_en_i && (issue_wr_reg_i == RW'(r))),
         .set_id_i     (issue_id_i),
         .wr_rel_cnt_i (wr_rel_cnt[r]),
         .rd_cnt_o     (rd_cnt[r]),
         .wr_pend_o    (wr_pend[r]),
         .wr_id_o      (wr_id_o[r*ID_WIDTH +: ID_WIDTH]),
         .err_o        (err_vec[r])
      );
      assign rd_busy_o[r] = |rd_cnt[r];
   end

   assign wr_busy_o = wr_pend;
   assign err_o     = |err_vec;
   assign idle_o    = !(|rd_busy_o) && !(|wr_pend);

endmodule

// File: tb/tb_quadrilatero_rf_scoreboard.sv
// tb/tb_quadrilatero_rf_scoreboard.sv - directed self-checking bench for the matrix RF hazard scoreboard
module tb_quadrilatero_rf_scoreboard;

   logic        clk = 1'b0;
   logic        rst_ni;
   logic        flush_i;
   logic        issue_valid_i;
   logic        issue_ready_o;
   logic [3:0]  issue_id_i;
   logic [2:0]  issue_rd_en_i;
   logic [8:0]  issue_rd_reg_i;
   logic        issue_wr_en_i;
   logic [2:0]  issue_wr_reg_i;
   logic [3:0]  rd_rel_valid_i;
   logic [11:0] rd_rel_reg_i;
   logic [2:0]  wr_rel_valid_i;
   logic [8:0]  wr_rel_reg_i;
   logic [7:0]  rd_busy_o;
   logic [7:0]  wr_busy_o;
   logic [31:0] wr_id_o;
   logic        err_o;
   logic        idle_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   quadrilatero_rf_scoreboard dut (
      .clk_i          (clk),
      .rst_ni         (rst_ni),
      .flush_i        (flush_i),
      .issue_valid_i  (issue_valid_i),
      .issue_ready_o  (issue_ready_o),
      .issue_id_i     (issue_id_i),
      .issue_rd_en_i  (issue_rd_en_i),
      .issue_rd_reg_i (issue_rd_reg_i),
      .issue_wr_en_i  (issue_wr_en_i),
      .issue_wr_reg_i (issue_wr_reg_i),
      .rd_rel_valid_i (rd_rel_valid_i),
      .rd_rel_reg_i   (rd_rel_reg_i),
      .wr_rel_valid_i (wr_rel_valid_i),
      .wr_rel_reg_i   (wr_rel_reg_i),
      .rd_busy_o      (rd_busy_o),
      .wr_busy_o      (wr_busy_o),
      .wr_id_o        (wr_id_o),
      .err_o          (err_o),
      .idle_o         (idle_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic clr();
      flush_i        = 1'b0;
      issue_valid_i  = 1'b0;
      issue_id_i     = '0;
      issue_rd_en_i  = '0;
      issue_rd_reg_i = '0;
      issue_wr_en_i  = 1'b0;
      issue_wr_reg_i = '0;
      rd_rel_valid_i = '0;
      rd_rel_reg_i   = '0;
      wr_rel_valid_i = '0;
      wr_rel_reg_i   = '0;
   endtask

   task automatic offer(input logic [3:0] id, input logic [2:0] en, input logic [8:0] regs,
                        input logic we, input logic [2:0] wr);
      issue_valid_i  = 1'b1;
      issue_id_i     = id;
      issue_rd_en_i  = en;
      issue_rd_reg_i = regs;
      issue_wr_en_i  = we;
      issue_wr_reg_i = wr;
   endtask

   initial begin
      rst_ni = 1'b0;
      clr();
      tick();
      tick();
      // Reset state
      offer(4'd0, 3'b000, 9'd0, 1'b0, 3'd0);
      #1;
      chk("rst_ready", issue_ready_o, 0);
      chk("rst_rd_busy", rd_busy_o, 0);
      chk("rst_wr_busy", wr_busy_o, 0);
      chk("rst_wr_id", wr_id_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_idle", idle_o, 1);
      clr();
      rst_ni = 1'b1;
      tick();

      // RAW: id=1 reads r0,r1,r2 writes r2; id=2 reads r2
      offer(4'd1, 3'b111, {3'd2, 3'd1, 3'd0}, 1'b1, 3'd2);
      #1 chk("id1_ready", issue_ready_o, 1);
      tick();
      clr();
      chk("id1_rd_busy", rd_busy_o, 8'h07);
      chk("id1_wr_busy", wr_busy_o, 8'h04);
      chk("id1_wr_id", wr_id_o, 32'h0000_0100);
      chk("id1_idle", idle_o, 0);
      offer(4'd2, 3'b001, {3'd0, 3'd0, 3'd2}, 1'b0, 3'd0);
      rd_rel_valid_i = 4'b0111;
      rd_rel_reg_i   = {3'd0, 3'd2, 3'd1, 3'd0};
      #1 chk("raw_ready", issue_ready_o, 0);
      tick();
      rd_rel_valid_i = '0;
      chk("rd_rel_busy", rd_busy_o, 8'h00);
      wr_rel_valid_i = 3'b001;
      wr_rel_reg_i   = {3'd0, 3'd0, 3'd2};
      #1 chk("raw_no_bypass", issue_ready_o, 0);
      tick();
      wr_rel_valid_i = '0;
      #1 chk("raw_release_ready", issue_ready_o, 1);
      chk("raw_wr_busy", wr_busy_o, 8'h00);
      tick();
      clr();
      chk("id2_rd_busy", rd_busy_o, 8'h04);
      chk("id2_err", err_o, 0);
      rd_rel_valid_i = 4'b0001;
      rd_rel_reg_i   = {9'd0, 3'd3 - 3'd1};
      tick();
      clr();
      chk("id2_idle", idle_o, 1);

      // Reader saturation on r3
      for (int k = 0; k < 3; k++) begin
         offer(4'(3 + k), 3'b001, {6'd0, 3'd3}, 1'b0, 3'd0);
         #1 chk("sat_fill_ready", issue_ready_o, 1);
         tick();
      end
      clr();
      chk("sat_rd_busy", rd_busy_o, 8'h08);
      offer(4'd6, 3'b001, {6'd0, 3'd3}, 1'b0, 3'd0);
      #1 chk("sat_stall", issue_ready_o, 0);
      rd_rel_valid_i = 4'b0001;
      rd_rel_reg_i   = {9'd0, 3'd3};
      #1 chk("sat_no_bypass", issue_ready_o, 0);
      tick();
      rd_rel_valid_i = '0;
      #1 chk("sat_release_ready", issue_ready_o, 1);
      tick();
      clr();
      chk("sat_refill_busy", rd_busy_o, 8'h08);
      rd_rel_valid_i = 4'b0111;
      rd_rel_reg_i   = {3'd0, 3'd3, 3'd3, 3'd3};
      tick();
      clr();
      chk("sat_drain_idle", idle_o, 1);
      chk("sat_drain_err", err_o, 0);

      // WAR on r4 with same-cycle issue+release
      offer(4'd7, 3'b001, {6'd0, 3'd4}, 1'b0, 3'd0);
      #1 chk("war_rd1_ready", issue_ready_o, 1);
      tick();
      clr();
      offer(4'd8, 3'b001, {6'd0, 3'd4}, 1'b0, 3'd0);
      rd_rel_valid_i = 4'b0001;
      rd_rel_reg_i   = {9'd0, 3'd4};
      #1 chk("war_rd2_ready", issue_ready_o, 1);
      tick();
      clr();
      offer(4'd9, 3'b000, 9'd0, 1'b1, 3'd4);
      #1 chk("war_stall", issue_ready_o, 0);
      chk("war_cnt_kept", rd_busy_o, 8'h10);
      tick();
      rd_rel_valid_i = 4'b0001;
      rd_rel_reg_i   = {9'd0, 3'd4};
      tick();
      rd_rel_valid_i = '0;
      #1 chk("war_release_ready", issue_ready_o, 1);
      tick();
      clr();
      chk("war_wr_busy", wr_busy_o, 8'h10);
      chk("war_wr_id", wr_id_o, 32'h0009_0000);
      chk("war_rd_busy", rd_busy_o, 8'h00);
      wr_rel_valid_i = 3'b100;
      wr_rel_reg_i   = {3'd4, 6'd0};
      tick();
      clr();
      chk("war_idle", idle_o, 1);
      chk("war_err", err_o, 0);

      // Release-accounting errors and flush
      wr_rel_valid_i = 3'b010;
      wr_rel_reg_i   = {3'd0, 3'd5, 3'd0};
      tick();
      clr();
      chk("spurious_wr_err", err_o, 1);
      chk("spurious_wr_busy", wr_busy_o, 8'h00);
      chk("spurious_idle", idle_o, 1);
      tick();
      chk("err_sticky", err_o, 1);
      flush_i = 1'b1;
      offer(4'd1, 3'b001, {6'd0, 3'd7}, 1'b0, 3'd0);
      #1 chk("flush_ready", issue_ready_o, 0);
      tick();
      clr();
      chk("flush_err", err_o, 0);
      chk("flush_idle", idle_o, 1);
      chk("flush_rd_busy", rd_busy_o, 8'h00);
      rd_rel_valid_i = 4'b0100;
      rd_rel_reg_i   = {3'd0, 3'd7, 6'd0};
      tick();
      clr();
      chk("underflow_err", err_o, 1);
      chk("underflow_busy", rd_busy_o, 8'h00);
      flush_i = 1'b1;
      tick();
      clr();
      chk("flush2_err", err_o, 0);
      offer(4'd7, 3'b000, 9'd0, 1'b1, 3'd1);
      #1 chk("dbl_setup_ready", issue_ready_o, 1);
      tick();
      clr();
      wr_rel_valid_i = 3'b011;
      wr_rel_reg_i   = {3'd0, 3'd1, 3'd1};
      tick();
      clr();
      chk("dbl_wr_err", err_o, 1);
      chk("dbl_wr_busy", wr_busy_o, 8'h00);
      flush_i = 1'b1;
      tick();
      clr();
      chk("flush3_err", err_o, 0);

      // Duplicate operands plus accumulator write on r6
      offer(4'd9, 3'b011, {3'd0, 3'd6, 3'd6}, 1'b1, 3'd6);
      #1 chk("acc_ready", issue_ready_o, 1);
      tick();
      clr();
      chk("acc_rd_busy", rd_busy_o, 8'h40);
      chk("acc_wr_busy", wr_busy_o, 8'h40);
      chk("acc_wr_id", wr_id_o, 32'h0900_0000);
      wr_rel_valid_i = 3'b001;
      wr_rel_reg_i   = {6'd0, 3'd6};
      tick();
      clr();
      offer(4'd10, 3'b011, {3'd0, 3'd6, 3'd6}, 1'b0, 3'd0);
      #1 chk("acc_cnt2_sat", issue_ready_o, 0);
      offer(4'd10, 3'b001, {6'd0, 3'd6}, 1'b0, 3'd0);
      #1 chk("acc_cnt2_room", issue_ready_o, 1);
      clr();
      rd_rel_valid_i = 4'b0011;
      rd_rel_reg_i   = {6'd0, 3'd6, 3'd6};
      tick();
      clr();
      chk("acc_drain_busy", rd_busy_o, 8'h00);
      chk("acc_drain_err", err_o, 0);
      chk("acc_drain_idle", idle_o, 1);

      // Reset mid-operation
      offer(4'd3, 3'b001, {6'd0, 3'd1}, 1'b1, 3'd0);
      tick();
      clr();
      wr_rel_valid_i = 3'b001;
      wr_rel_reg_i   = {6'd0, 3'd5};
      tick();
      clr();
      chk("mid_err", err_o, 1);
      chk("mid_idle", idle_o, 0);
      rst_ni = 1'b0;
      #1 chk("mid_rst_ready", issue_ready_o, 0);
      tick();
      rst_ni = 1'b1;
      chk("post_rst_rd_busy", rd_busy_o, 8'h00);
      chk("post_rst_wr_busy", wr_busy_o, 8'h00);
      chk("post_rst_wr_id", wr_id_o, 0);
      chk("post_rst_err", err_o, 0);
      chk("post_rst_idle", idle_o, 1);
      offer(4'd4, 3'b111, {3'd2, 3'd1, 3'd0}, 1'b1, 3'd0);
      #1 chk("post_rst_ready", issue_ready_o, 1);
      tick();
      clr();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
